// File: rtl/pcm_packetizer_if.sv
// pcm_packetizer_if
//   Bundles the PCM input, BRAM write port and transmitter handshake of the
//   PCM packetizer.
//   master : packetizer side (receives PCM + tx_busy, drives BRAM + tx).
//   slave  : environment side (PCM source, BRAM, Ethernet transmitter).
//   Signals:
//     pcm_stb   one-cycle strobe, pcm_data valid
//     pcm_data  CHANNELS*SAMPLE_W samples, channel 0 in LSBs
//     wr_en     BRAM write enable
//     wr_addr   BRAM byte address, MSB selects the bank
//     wr_data   BRAM write byte
//     tx_start  one-cycle pulse, a packet is ready
//     tx_bank   bank holding the packet, held until the next tx_start
//     tx_busy   Ethernet transmitter busy
//     drop_cnt  saturating count of dropped frames plus dropped packets
interface pcm_packetizer_if #(
    parameter int CHANNELS = 2,
    parameter int SAMPLE_W = 16,
    parameter int ADDR_W   = 11
);
    logic                         pcm_stb;
    logic [CHANNELS*SAMPLE_W-1:0] pcm_data;
    logic                         wr_en;
    logic [ADDR_W-1:0]            wr_addr;
    logic [7:0]                   wr_data;
    logic                         tx_start;
    logic                         tx_bank;
    logic                         tx_busy;
    logic [7:0]                   drop_cnt;

    modport master (
        input  pcm_stb, pcm_data, tx_busy,
        output wr_en, wr_addr, wr_data, tx_start, tx_bank, drop_cnt
    );

    modport slave (
        output pcm_stb, pcm_data, tx_busy,
        input  wr_en, wr_addr, wr_data, tx_start, tx_bank, drop_cnt
    );
endinterface

// File: rtl/pcm_packetizer.sv
// pcm_packetizer
//   Serialises multi-channel PCM frames byte-wise into a two-bank packet
//   BRAM behind a fixed header area. A full bank triggers tx_start and
//   capture continues in the other bank. Frames arriving while busy and
//   packets that find the transmitter busy are counted in drop_cnt.
//   Ports:
//     clk    system clock
//     rst_n  synchronous active-low reset
//     bus    pcm_packetizer_if.master (PCM in, BRAM write, tx handshake)
//   Optional feature: define PCM_PACKETIZER_SEQ_EN to write a big-endian
//   16-bit packet sequence number right after the header.
module pcm_packetizer #(
    parameter int CHANNELS  = 2,
    parameter int SAMPLE_W  = 16,
    parameter int FRAMES    = 32,
    parameter int HDR_BYTES = 14,
    parameter int ADDR_W    = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    pcm_packetizer_if.master   bus
);
    localparam int DATA_BITS  = CHANNELS * SAMPLE_W;
    localparam int BPF        = DATA_BITS / 8;
`ifdef PCM_PACKETIZER_SEQ_EN
    localparam int PO         = HDR_BYTES + 2;
`else
    localparam int PO         = HDR_BYTES;
`endif
    localparam int BANK_BYTES = 2 ** (ADDR_W - 1);
    localparam int OFF_W      = ADDR_W - 1;
    localparam int FRAME_W    = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int BYTE_W     = (BPF > 1) ? $clog2(BPF) : 1;

    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAMES - 1);
    localparam logic [BYTE_W-1:0]  LAST_BYTE  = BYTE_W'(BPF - 1);
    localparam logic [OFF_W-1:0]   PO_OFF     = OFF_W'(PO);

    if (PO + FRAMES * BPF > BANK_BYTES) begin : g_payload_too_big
        $error("pcm_packetizer: header plus payload does not fit in one bank");
    end
    if ((SAMPLE_W % 8) != 0) begin : g_bad_sample_w
        $error("pcm_packetizer: SAMPLE_W must be a multiple of 8");
    end

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
`ifdef PCM_PACKETIZER_SEQ_EN
        SEQ_HI,
        SEQ_LO,
`endif
        DONE
    } state_t;

    state_t                 state, state_nx;
    logic                   bank;
    logic [FRAME_W-1:0]     frame;
    logic [BYTE_W-1:0]      byte_idx;
    logic [OFF_W-1:0]       off;        // running payload offset inside the bank
    logic [DATA_BITS-1:0]   shadow;     // shifted right one byte per write
    logic                   tx_bank_q;
    logic [7:0]             drop_cnt;
`ifdef PCM_PACKETIZER_SEQ_EN
    logic [15:0]            seq;
`endif

    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [7:0]             wr_data;
    logic                   tx_start;
    logic                   frame_drop;
    logic                   pkt_drop;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    assign frame_drop = bus.pcm_stb && (state != IDLE);
    assign pkt_drop   = (state == DONE) && bus.tx_busy;

    always_comb begin
        state_nx = state;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        tx_start = 1'b0;
        case (state)
            IDLE: begin
                if (bus.pcm_stb) state_nx = WRITE;
            end
            WRITE: begin
                wr_en   = 1'b1;
                wr_addr = {bank, off};
                wr_data = shadow[7:0];
                if (byte_idx == LAST_BYTE) begin
                    if (frame == LAST_FRAME) begin
`ifdef PCM_PACKETIZER_SEQ_EN
                        state_nx = SEQ_HI;
`else
                        state_nx = DONE;
`endif
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
`ifdef PCM_PACKETIZER_SEQ_EN
            SEQ_HI: begin
                wr_en    = 1'b1;
                wr_addr  = {bank, OFF_W'(HDR_BYTES)};
                wr_data  = seq[15:8];
                state_nx = SEQ_LO;
            end
            SEQ_LO: begin
                wr_en    = 1'b1;
                wr_addr  = {bank, OFF_W'(HDR_BYTES + 1)};
                wr_data  = seq[7:0];
                state_nx = DONE;
            end
`endif
            DONE: begin
                tx_start = !bus.tx_busy;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            bank      <= 1'b0;
            frame     <= '0;
            byte_idx  <= '0;
            off       <= PO_OFF;
            tx_bank_q <= 1'b0;
            drop_cnt  <= 8'd0;
`ifdef PCM_PACKETIZER_SEQ_EN
            seq       <= 16'd0;
`endif
        end else begin
            state    <= state_nx;
            drop_cnt <= sat_add(drop_cnt, {1'b0, pkt_drop} + {1'b0, frame_drop});
            case (state)
                WRITE: begin
                    off <= off + 1'b1;
                    if (byte_idx == LAST_BYTE) begin
                        byte_idx <= '0;
                        if (frame != LAST_FRAME) frame <= frame + 1'b1;
                    end else begin
                        byte_idx <= byte_idx + 1'b1;
                    end
                end
                DONE: begin
                    // A dropped packet rewinds into the same bank and keeps its number.
                    frame <= '0;
                    off   <= PO_OFF;
                    if (!bus.tx_busy) begin
                        bank      <= ~bank;
                        tx_bank_q <= bank;
`ifdef PCM_PACKETIZER_SEQ_EN
                        seq       <= seq + 16'd1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Data path: shadow capture has no reset, only the FSM qualifies it.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.pcm_stb) shadow <= bus.pcm_data;
        else if (state == WRITE)          shadow <= shadow >> 8;
    end

    assign bus.wr_en    = wr_en;
    assign bus.wr_addr  = wr_addr;
    assign bus.wr_data  = wr_data;
    assign bus.tx_start = tx_start;
    // Current bank is shown during the start pulse, the latched one afterwards.
    assign bus.tx_bank  = tx_start ? bank : tx_bank_q;
    assign bus.drop_cnt = drop_cnt;
endmodule

// File: tb/tb_pcm_packetizer.sv
// tb_pcm_packetizer
//   Directed bench for pcm_packetizer with FRAMES=4, two 16-bit channels.
//   Honours PCM_PACKETIZER_SEQ_EN for payload offset and sequence bytes.
module tb_pcm_packetizer;
    localparam int BPF  = 4;
    localparam int BANK = 1024;
    localparam int HDR  = 14;
`ifdef PCM_PACKETIZER_SEQ_EN
    localparam int PO   = 16;
`else
    localparam int PO   = 14;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pcm_packetizer_if #(.CHANNELS(2), .SAMPLE_W(16), .ADDR_W(11)) bus ();

    pcm_packetizer #(
        .CHANNELS(2), .SAMPLE_W(16), .FRAMES(4), .HDR_BYTES(14), .ADDR_W(11)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe one frame and check its BPF byte writes.
    task automatic do_frame(input logic [31:0] d, input int bank, input int fr);
        bus.pcm_stb  = 1'b1;
        bus.pcm_data = d;
        tick();
        bus.pcm_stb  = 1'b0;
        for (int k = 0; k < BPF; k++) begin
            @(negedge clk);
            chk("wr_en",   32'(bus.wr_en),   32'd1);
            chk("wr_addr", 32'(bus.wr_addr), 32'(bank * BANK + PO + fr * BPF + k));
            chk("wr_data", 32'(bus.wr_data), 32'(d[8*k +: 8]));
            tick();
        end
    endtask

    task automatic check_idle();
        @(negedge clk);
        chk("idle_wr_en",    32'(bus.wr_en),    32'd0);
        chk("idle_tx_start", 32'(bus.tx_start), 32'd0);
        tick();
    endtask

    task automatic finish_packet(input int bank, input int seq, input bit stb_done,
                                 input bit exp_start, input bit exp_tx_bank);
`ifdef PCM_PACKETIZER_SEQ_EN
        @(negedge clk);
        chk("seq_hi_en",   32'(bus.wr_en),   32'd1);
        chk("seq_hi_addr", 32'(bus.wr_addr), 32'(bank * BANK + HDR));
        chk("seq_hi_data", 32'(bus.wr_data), 32'((seq >> 8) & 255));
        tick();
        @(negedge clk);
        chk("seq_lo_en",   32'(bus.wr_en),   32'd1);
        chk("seq_lo_addr", 32'(bus.wr_addr), 32'(bank * BANK + HDR + 1));
        chk("seq_lo_data", 32'(bus.wr_data), 32'(seq & 255));
        tick();
`endif
        bus.pcm_stb  = stb_done;
        bus.pcm_data = 32'h5555AAAA;
        @(negedge clk);
        chk("done_wr_en", 32'(bus.wr_en),    32'd0);
        chk("tx_start",   32'(bus.tx_start), 32'(exp_start));
        chk("tx_bank",    32'(bus.tx_bank),  32'(exp_tx_bank));
        tick();
        bus.pcm_stb = 1'b0;
        @(negedge clk);
        chk("post_done_start", 32'(bus.tx_start), 32'd0);
        chk("post_done_bank",  32'(bus.tx_bank),  32'(exp_tx_bank));
        tick();
    endtask

    task automatic full_packet(input int bank, input int seq, input bit stb_done,
                               input bit exp_start, input bit exp_tx_bank);
        logic [31:0] dat [4];
        dat = '{32'hABCD1234, 32'h00FF8001, 32'h7FFF8000, 32'hDEADBEEF};
        for (int f = 0; f < 4; f++) begin
            do_frame(dat[f], bank, f);
            if (f < 3) check_idle();
        end
        finish_packet(bank, seq, stb_done, exp_start, exp_tx_bank);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n        = 1'b0;
        bus.pcm_stb  = 1'b0;
        bus.pcm_data = '0;
        bus.tx_busy  = 1'b0;
        tick(); tick(); tick();
        @(negedge clk);
        chk("rst_wr_en",    32'(bus.wr_en),    32'd0);
        chk("rst_wr_addr",  32'(bus.wr_addr),  32'd0);
        chk("rst_wr_data",  32'(bus.wr_data),  32'd0);
        chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
        chk("rst_tx_bank",  32'(bus.tx_bank),  32'd0);
        chk("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Packet A: bank 0, sent.
        full_packet(0, 0, 1'b0, 1'b1, 1'b0);
        chk("drop_after_a", 32'(bus.drop_cnt), 32'd0);

        // Packet B: bank 1, transmitter busy; strobe in DONE also dropped (+2).
        bus.tx_busy = 1'b1;
        full_packet(1, 1, 1'b1, 1'b0, 1'b0);
        bus.tx_busy = 1'b0;
        chk("drop_after_b", 32'(bus.drop_cnt), 32'd2);

        // Packet C: same bank 1 again, same sequence number, sent.
        full_packet(1, 1, 1'b0, 1'b1, 1'b1);
        chk("drop_after_c", 32'(bus.drop_cnt), 32'd2);

        // Packet D: bank 0, frame 0 gets a second strobe at T+2 which is dropped.
        bus.pcm_stb  = 1'b1;
        bus.pcm_data = 32'h89AB4567;
        tick();
        for (int k = 0; k < BPF; k++) begin
            bus.pcm_stb  = (k == 1);
            bus.pcm_data = (k == 1) ? 32'hFFFFFFFF : 32'h0;
            @(negedge clk);
            chk("drop_wr_addr", 32'(bus.wr_addr), 32'(PO + k));
            tick();
        end
        bus.pcm_stb = 1'b0;
        check_idle();
        chk("drop_after_frame", 32'(bus.drop_cnt), 32'd3);
        do_frame(32'h11223344, 0, 1); check_idle();
        do_frame(32'h55667788, 0, 2); check_idle();
        do_frame(32'h99AABBCC, 0, 3);
        finish_packet(0, 2, 1'b0, 1'b1, 1'b0);

        // Packet E: bank 1, reset during the fourth frame.
        do_frame(32'h01020304, 1, 0); check_idle();
        do_frame(32'h05060708, 1, 1); check_idle();
        do_frame(32'h090A0B0C, 1, 2); check_idle();
        bus.pcm_stb  = 1'b1;
        bus.pcm_data = 32'hCAFEF00D;
        tick();
        bus.pcm_stb = 1'b0;
        @(negedge clk);
        chk("e_last_byte0", 32'(bus.wr_data), 32'h0D);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("e_pre_rst_en", 32'(bus.wr_en), 32'd1);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("e_rst_wr_en",  32'(bus.wr_en),    32'd0);
        chk("e_rst_drop",   32'(bus.drop_cnt), 32'd0);
        chk("e_rst_bank",   32'(bus.tx_bank),  32'd0);
        tick();
        for (int i = 0; i < 6; i++) check_idle();

        // Packet F: restarts at bank 0, payload offset.
        do_frame(32'hABCD1234, 0, 0);
        check_idle();

        // Continuous strobes: drop count must stick at 255.
        bus.pcm_stb = 1'b1;
        for (int i = 0; i < 400; i++) tick();
        bus.pcm_stb = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        @(negedge clk);
        chk("drop_saturate", 32'(bus.drop_cnt), 32'd255);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
